// File: rtl/cl2_pl_exu_regfile_mp.sv
// Multi-port integer register file for the CL2 EXU. It supports optional same-cycle
// write-to-read bypass and a per-register busy scoreboard for writeback hazards.
module cl2_pl_exu_regfile_mp #(
    parameter int XLEN     = 32,
    parameter int REG_NUM  = 32,
    parameter int RD_PORTS = 2,
    parameter int WR_PORTS = 1,
    parameter int BYPASS   = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic                                 tm_i,
    input  logic [RD_PORTS*$clog2(REG_NUM)-1:0]  rd_idx_i,
    output logic [RD_PORTS*XLEN-1:0]             rd_dat_o,
    output logic [RD_PORTS-1:0]                  rd_busy_o,
    input  logic [WR_PORTS-1:0]                  wr_en_i,
    input  logic [WR_PORTS*$clog2(REG_NUM)-1:0]  wr_idx_i,
    input  logic [WR_PORTS*XLEN-1:0]             wr_dat_i,
    input  logic                                 iss_en_i,
    input  logic [$clog2(REG_NUM)-1:0]           iss_idx_i,
    output logic                                 wr_conflict_o
);

    localparam int AW = $clog2(REG_NUM);

    logic [XLEN-1:0]    r_regs [1:REG_NUM-1];
    logic [REG_NUM-1:1] r_busy;
    logic               r_conflict;

    logic [REG_NUM-1:1] w_we;
    logic [XLEN-1:0]    w_wd [1:REG_NUM-1];
    logic               w_conflict;
    logic               w_byp;

    assign w_byp = (BYPASS != 0) && !tm_i;

    // Per-register write decode; later ports override earlier ones.
    always_comb begin
        for (int i = 1; i < REG_NUM; i++) begin
            w_we[i] = 1'b0;
            w_wd[i] = '0;
            for (int w = 0; w < WR_PORTS; w++) begin
                if (wr_en_i[w] && (wr_idx_i[w*AW +: AW] == AW'(i))) begin
                    w_we[i] = 1'b1;
                    w_wd[i] = wr_dat_i[w*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int w = 0; w < WR_PORTS; w++) begin
            for (int v = w + 1; v < WR_PORTS; v++) begin
                if (wr_en_i[w] && wr_en_i[v] &&
                    (wr_idx_i[w*AW +: AW] == wr_idx_i[v*AW +: AW]) &&
                    (wr_idx_i[w*AW +: AW] != '0)) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 1; i < REG_NUM; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (w_we[i]) r_regs[i] <= w_wd[i];
            end
        end
    end

    // A new issue supersedes a writeback landing on the same edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_busy     <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= w_conflict;
            for (int i = 1; i < REG_NUM; i++) begin
                if (iss_en_i && (iss_idx_i == AW'(i))) r_busy[i] <= 1'b1;
                else if (w_we[i])                      r_busy[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_dat_o  = '0;
        rd_busy_o = '0;
        for (int r = 0; r < RD_PORTS; r++) begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (rd_idx_i[r*AW +: AW] == AW'(i)) begin
                    if (w_byp && w_we[i]) begin
                        rd_dat_o[r*XLEN +: XLEN] = w_wd[i];
                        rd_busy_o[r]             = 1'b0;
                    end else begin
                        rd_dat_o[r*XLEN +: XLEN] = r_regs[i];
                        rd_busy_o[r]             = r_busy[i];
                    end
                end
            end
        end
    end

    assign wr_conflict_o = r_conflict;

endmodule

// File: tb/tb_cl2_pl_exu_regfile_mp.sv
// Bench for cl2_pl_exu_regfile_mp at RD_PORTS=4, WR_PORTS=2, REG_NUM=16 with bypass enabled.
module tb_cl2_pl_exu_regfile_mp;
    localparam int XLEN = 32;
    localparam int REG_NUM = 16;
    localparam int RD_PORTS = 4;
    localparam int WR_PORTS = 2;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    logic                     tm;
    logic [RD_PORTS*AW-1:0]   rd_idx;
    logic [RD_PORTS*XLEN-1:0] rd_dat;
    logic [RD_PORTS-1:0]      rd_busy;
    logic [WR_PORTS-1:0]      wr_en;
    logic [WR_PORTS*AW-1:0]   wr_idx;
    logic [WR_PORTS*XLEN-1:0] wr_dat;
    logic                     iss_en;
    logic [AW-1:0]            iss_idx;
    logic                     conflict;

    cl2_pl_exu_regfile_mp #(
        .XLEN(XLEN), .REG_NUM(REG_NUM), .RD_PORTS(RD_PORTS), .WR_PORTS(WR_PORTS), .BYPASS(1)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .tm_i(tm),
        .rd_idx_i(rd_idx), .rd_dat_o(rd_dat), .rd_busy_o(rd_busy),
        .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_dat_i(wr_dat),
        .iss_en_i(iss_en), .iss_idx_i(iss_idx), .wr_conflict_o(conflict)
    );

    // Architectural state as the specification describes it.
    logic [31:0] m_reg  [REG_NUM];
    logic        m_busy [REG_NUM];
    logic        m_conf;
    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < REG_NUM; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_conf = 1'b0;
    endtask

    task automatic model_update();
        int hits [REG_NUM];
        if (!rst_n) begin
            model_clear();
        end else begin
            for (int i = 0; i < REG_NUM; i++) hits[i] = 0;
            for (int w = 0; w < WR_PORTS; w++)
                if (wr_en[w]) hits[wr_idx[w*AW +: AW]]++;
            m_conf = 1'b0;
            for (int i = 1; i < REG_NUM; i++) if (hits[i] > 1) m_conf = 1'b1;
            for (int w = 0; w < WR_PORTS; w++) begin
                if (wr_en[w] && wr_idx[w*AW +: AW] != 0) begin
                    m_reg[wr_idx[w*AW +: AW]]  = wr_dat[w*XLEN +: XLEN];
                    m_busy[wr_idx[w*AW +: AW]] = 1'b0;
                end
            end
            if (iss_en && iss_idx != 0) m_busy[iss_idx] = 1'b1;
        end
    endtask

    task automatic model_compare();
        logic [3:0]  idx;
        logic [31:0] ed;
        logic        eb;
        for (int r = 0; r < RD_PORTS; r++) begin
            idx = rd_idx[r*AW +: AW];
            ed = '0;
            eb = 1'b0;
            if (idx != 0) begin
                ed = m_reg[idx];
                eb = m_busy[idx];
                if (!tm) begin
                    for (int w = 0; w < WR_PORTS; w++) begin
                        if (wr_en[w] && wr_idx[w*AW +: AW] == idx) begin
                            ed = wr_dat[w*XLEN +: XLEN];
                            eb = 1'b0;
                        end
                    end
                end
            end
            chk($sformatf("model_rd_dat%0d", r), rd_dat[r*XLEN +: XLEN], ed);
            chk($sformatf("model_rd_busy%0d", r), {31'b0, rd_busy[r]}, {31'b0, eb});
        end
        chk("model_conflict", {31'b0, conflict}, {31'b0, m_conf});
    endtask

    task automatic settle();
        @(negedge clk);
        model_compare();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        wr_en  = '0;
        wr_idx = '0;
        wr_dat = '0;
        iss_en = 1'b0;
        iss_idx = '0;
    endtask

    task automatic set_rd(input int r, input logic [3:0] idx);
        rd_idx[r*AW +: AW] = idx;
    endtask

    task automatic set_wr(input int w, input logic [3:0] idx, input logic [31:0] d);
        wr_en[w] = 1'b1;
        wr_idx[w*AW +: AW] = idx;
        wr_dat[w*XLEN +: XLEN] = d;
    endtask

    function automatic logic [31:0] rdat(input int r);
        return rd_dat[r*XLEN +: XLEN];
    endfunction

    initial begin
        rst_n = 1'b1;
        tm = 1'b0;
        rd_idx = '0;
        idle();
        model_clear();
        #1 rst_n = 1'b0;
        model_clear();
        repeat (3) begin settle(); adv(); end
        rst_n = 1'b1;

        // Reset state
        for (int r = 0; r < RD_PORTS; r++) set_rd(r, 4'd5);
        settle();
        for (int r = 0; r < RD_PORTS; r++) begin
            chk("rst_dat", rdat(r), 32'h0);
            chk("rst_busy", {31'b0, rd_busy[r]}, 32'h0);
        end
        chk("rst_conflict", {31'b0, conflict}, 32'h0);
        adv();

        // Bypass write, then storage
        set_rd(0, 4'd7);
        set_wr(0, 4'd7, 32'h12345678);
        settle();
        chk("byp_same_cycle", rdat(0), 32'h12345678);
        adv();
        idle();
        settle();
        chk("byp_next_cycle", rdat(0), 32'h12345678);
        adv();

        // Test mode kills bypass
        tm = 1'b1;
        set_wr(0, 4'd7, 32'hCAFEF00D);
        settle();
        chk("tm_old_value", rdat(0), 32'h12345678);
        adv();
        idle();
        settle();
        chk("tm_new_value", rdat(0), 32'hCAFEF00D);
        adv();
        tm = 1'b0;

        // x0 is hardwired
        set_rd(1, 4'd0);
        set_wr(0, 4'd0, 32'hFFFFFFFF);
        set_wr(1, 4'd0, 32'hFFFFFFFF);
        iss_en = 1'b1;
        iss_idx = 4'd0;
        settle();
        chk("x0_dat_same", rdat(1), 32'h0);
        chk("x0_busy_same", {31'b0, rd_busy[1]}, 32'h0);
        adv();
        idle();
        settle();
        chk("x0_dat_next", rdat(1), 32'h0);
        chk("x0_busy_next", {31'b0, rd_busy[1]}, 32'h0);
        chk("x0_no_conflict", {31'b0, conflict}, 32'h0);
        adv();

        // Scoreboard: issue x3, writeback four cycles later
        set_rd(2, 4'd3);
        iss_en = 1'b1;
        iss_idx = 4'd3;
        settle();
        chk("x3_busy_N", {31'b0, rd_busy[2]}, 32'h0);
        adv();
        idle();
        for (int k = 1; k <= 3; k++) begin
            settle();
            chk($sformatf("x3_busy_N+%0d", k), {31'b0, rd_busy[2]}, 32'h1);
            adv();
        end
        set_wr(0, 4'd3, 32'h00000033);
        settle();
        chk("x3_busy_N+4", {31'b0, rd_busy[2]}, 32'h0);
        chk("x3_dat_N+4", rdat(2), 32'h00000033);
        adv();
        idle();
        settle();
        chk("x3_busy_N+5", {31'b0, rd_busy[2]}, 32'h0);
        adv();

        // Issue and writeback of x9 on the same edge: issue wins
        set_rd(3, 4'd9);
        set_wr(1, 4'd9, 32'h00000099);
        iss_en = 1'b1;
        iss_idx = 4'd9;
        settle();
        chk("x9_dat_same", rdat(3), 32'h00000099);
        chk("x9_busy_same", {31'b0, rd_busy[3]}, 32'h0);
        adv();
        idle();
        settle();
        chk("x9_busy_after", {31'b0, rd_busy[3]}, 32'h1);
        chk("x9_dat_after", rdat(3), 32'h00000099);
        adv();

        // Two write ports on x4
        set_rd(0, 4'd4);
        set_wr(0, 4'd4, 32'h0000AAAA);
        set_wr(1, 4'd4, 32'h00005555);
        settle();
        chk("x4_byp_port1_wins", rdat(0), 32'h00005555);
        chk("x4_conflict_same", {31'b0, conflict}, 32'h0);
        adv();
        idle();
        settle();
        chk("x4_stored", rdat(0), 32'h00005555);
        chk("x4_conflict_next", {31'b0, conflict}, 32'h1);
        adv();
        settle();
        chk("x4_conflict_gone", {31'b0, conflict}, 32'h0);
        adv();

        // Reset mid-run discards contents and busy bits
        for (int r = 0; r < RD_PORTS; r++) set_rd(r, 4'd5);
        set_wr(0, 4'd5, 32'hDEADBEEF);
        iss_en = 1'b1;
        iss_idx = 4'd5;
        settle();
        adv();
        idle();
        settle();
        chk("x5_before_rst", rdat(1), 32'hDEADBEEF);
        chk("x5_busy_before_rst", {31'b0, rd_busy[1]}, 32'h1);
        adv();
        rst_n = 1'b0;
        model_clear();
        settle();
        for (int r = 0; r < RD_PORTS; r++) begin
            chk("midrst_dat", rdat(r), 32'h0);
            chk("midrst_busy", {31'b0, rd_busy[r]}, 32'h0);
        end
        adv();
        rst_n = 1'b1;
        set_rd(3, 4'd9);
        settle();
        chk("postrst_x5", rdat(0), 32'h0);
        chk("postrst_x9_busy", {31'b0, rd_busy[3]}, 32'h0);
        adv();

        // Mixed traffic checked against the model only
        for (int c = 0; c < 3000; c++) begin
            rd_idx  = 16'($urandom);
            wr_en   = 2'($urandom);
            wr_idx  = 8'($urandom);
            wr_dat  = {$urandom, $urandom};
            iss_en  = 1'($urandom);
            iss_idx = 4'($urandom);
            tm      = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                model_clear();
            end else begin
                rst_n = 1'b1;
            end
            settle();
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
